// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block_ram_dpi port between N_REQ requesters, with read-return routing.
// Define BRAM_ARB_BURST_EN to enable locked bursts (up to MAX_BURST consecutive grants to one owner).
module bram_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       bram_addr,
  output logic [DW-1:0]       bram_wdata,
  output logic                bram_wen,
  input  logic [DW-1:0]       bram_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  logic [IW-1:0] rr_ptr, rr_nx, arb_win, win;
  logic          arb_found, granted;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rd_vld_p [RD_LAT];
  logic [IW-1:0] rd_id_p  [RD_LAT];

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_win   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_win   = idx[IW-1:0];
      end
    end
  end

`ifdef BRAM_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_t;
  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [BW-1:0] beat_cnt, beat_nx;

  // Dropping req while locked falls through to normal arbitration in the same cycle
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    beat_nx  = beat_cnt;
    rr_nx    = rr_ptr;
    granted  = 1'b0;
    win      = arb_win;
    if (rst_n) begin
      if (state == LOCKED && req[owner]) begin
        granted = 1'b1;
        win     = owner;
        beat_nx = beat_cnt + 1'b1;
        if (!req_lock[owner] || beat_nx == BW'(MAX_BURST)) begin
          state_nx = ARB;
          beat_nx  = '0;
          rr_nx    = next_id(owner);
        end
      end else begin
        state_nx = ARB;
        beat_nx  = '0;
        if (arb_found) begin
          granted = 1'b1;
          rr_nx   = next_id(arb_win);
          if (req_lock[arb_win] && MAX_BURST > 1) begin
            state_nx = LOCKED;
            owner_nx = arb_win;
            beat_nx  = BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      beat_cnt <= beat_nx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    granted = rst_n & arb_found;
    win     = arb_win;
    rr_nx   = granted ? next_id(arb_win) : rr_ptr;
  end
`endif

  always_comb begin
    gnt = '0;
    if (granted) gnt[win] = 1'b1;
  end

  assign bram_wen   = granted & req_we[win];
  assign bram_addr  = granted ? req_addr[win*AW +: AW]  : addr_q;
  assign bram_wdata = granted ? req_wdata[win*DW +: DW] : wdata_q;
  assign rdata      = bram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rr_ptr <= rr_nx;
      if (granted) begin
        addr_q  <= req_addr[win*AW +: AW];
        wdata_q <= req_wdata[win*DW +: DW];
      end
    end
  end

  // Read-return pipe: stage p0 captured at the grant edge, rvalid taken from the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_vld_p[i] <= 1'b0;
    end else begin
      rd_vld_p[0] <= granted & ~req_we[win];
      for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_id_p[0] <= win;
    for (int i = 1; i < RD_LAT; i++) rd_id_p[i] <= rd_id_p[i-1];
  end

  always_comb begin
    rvalid = '0;
    if (rd_vld_p[RD_LAT-1]) rvalid[rd_id_p[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter (N_REQ=3, RD_LAT=2) with a BRAM model and read-return scoreboard.
module tb_bram_port_arbiter;
  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int RD_LAT = 2;
  localparam int MAXB   = 4;

  logic            clk, rst_n;
  logic [N-1:0]    req, req_we, req_lock, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, bram_wdata, bram_rdata;
  logic [AW-1:0]   bram_addr;
  logic            bram_wen;

  bram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wen(bram_wen), .bram_rdata(bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-before-write, RD_LAT-cycle read latency
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bram_wen) mem[bram_addr[7:0]] <= bram_wdata;
    rd_pipe[0] <= mem[bram_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int unsigned  due;
    logic [N-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
        mon_e = sb.pop_front();
        check("rvalid", 64'(rvalid), 64'(mon_e.oh));
        check("rdata", rdata, mon_e.data);
      end else if (rvalid !== '0) begin
        check("rvalid_unexpected", 64'(rvalid), 64'(0));
      end
    end
  end

  task automatic set_port(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]                = we;
    req_addr[i*AW +: AW]     = a;
    req_wdata[i*DW +: DW]    = d;
  endtask

  // Drive one cycle from a negedge; record accepted reads/writes into the reference model
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] lk, output logic [N-1:0] g,
                       output logic wen, output logic [AW-1:0] a_o, output logic [DW-1:0] d_o);
    logic [AW-1:0] a;
    req      = r;
    req_lock = lk;
    #1;
    g   = gnt;
    wen = bram_wen;
    a_o = bram_addr;
    d_o = bram_wdata;
    for (int i = 0; i < N; i++) begin
      if (g[i] && rst_n) begin
        a = req_addr[i*AW +: AW];
        if (req_we[i]) ref_mem[a[7:0]] = req_wdata[i*DW +: DW];
        else sb.push_back('{cyc_n + RD_LAT, N'(1 << i), ref_mem[a[7:0]]});
      end
    end
    @(negedge clk);
  endtask

  logic [N-1:0]  g;
  logic          w;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [N-1:0]  exp_g;
  int            cnt [N];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 64'h0123_4500_0000_0000 | 64'(i);
      ref_mem[i] = 64'h0123_4500_0000_0000 | 64'(i);
    end
    rst_n = 1'b0; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    set_port(0, 1'b0, 32'h20, '0);
    set_port(1, 1'b0, 32'h21, '0);
    set_port(2, 1'b0, 32'h30, '0);
    repeat (2) @(negedge clk);

    // Reset held with requests pending
    cycle(3'b011, '0, g, w, a, d);
    check("rst_gnt", 64'(g), 64'(0));
    check("rst_wen", 64'(w), 64'(0));
    check("rst_addr", 64'(a), 64'(0));
    check("rst_wdata", d, 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    rst_n = 1'b1;
    cycle(3'b011, '0, g, w, a, d);
    check("first_gnt", 64'(g), 64'(3'b001));
    cycle(3'b011, '0, g, w, a, d);
    check("second_gnt", 64'(g), 64'(3'b010));

    // Write then read back the same address
    set_port(0, 1'b1, 32'h10, 64'hDEAD_BEEF_0123_4567);
    cycle(3'b001, '0, g, w, a, d);
    check("wr_gnt", 64'(g), 64'(3'b001));
    check("wr_wen", 64'(w), 64'(1));
    check("wr_addr", 64'(a), 64'h10);
    check("wr_wdata", d, 64'hDEAD_BEEF_0123_4567);
    set_port(0, 1'b0, 32'h10, '0);
    cycle(3'b001, '0, g, w, a, d);
    check("rd_gnt", 64'(g), 64'(3'b001));
    check("rd_wen", 64'(w), 64'(0));
    cycle(3'b000, '0, g, w, a, d);
    check("idle_gnt", 64'(g), 64'(0));
    check("idle_wen", 64'(w), 64'(0));
    check("idle_addr_hold", 64'(a), 64'h10);
    repeat (3) cycle(3'b000, '0, g, w, a, d);

    // Fairness: park rr_ptr at 0, then all three requesting
    cycle(3'b100, '0, g, w, a, d);
    check("park_gnt", 64'(g), 64'(3'b100));
    set_port(0, 1'b0, 32'h20, '0);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 9; k++) begin
      cycle(3'b111, '0, g, w, a, d);
      exp_g = N'(1 << (k % N));
      check("rr_order", 64'(g), 64'(exp_g));
      for (int i = 0; i < N; i++) if (g[i]) cnt[i]++;
    end
    for (int i = 0; i < N; i++) check("rr_count", 64'(cnt[i]), 64'(3));
    repeat (3) cycle(3'b000, '0, g, w, a, d);

    // Pipelined reads from requester 1
    for (int k = 0; k < 3; k++) begin
      set_port(1, 1'b0, 32'(k), '0);
      cycle(3'b010, '0, g, w, a, d);
      check("pipe_gnt", 64'(g), 64'(3'b010));
    end
    repeat (4) cycle(3'b000, '0, g, w, a, d);

    // Reset while a read is in flight
    set_port(0, 1'b0, 32'h5, '0);
    cycle(3'b001, '0, g, w, a, d);
    check("inflight_gnt", 64'(g), 64'(3'b001));
    rst_n = 1'b0;
    sb.delete();
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(3'b000, '0, g, w, a, d);
      check("dropped_rvalid", 64'(rvalid), 64'(0));
    end
    cycle(3'b111, '0, g, w, a, d);
    check("post_rst_gnt", 64'(g), 64'(3'b001));
    cycle(3'b111, '0, g, w, a, d);
    check("post_rst_gnt2", 64'(g), 64'(3'b010));
    cycle(3'b100, '0, g, w, a, d);
    check("park2_gnt", 64'(g), 64'(3'b100));
    repeat (3) cycle(3'b000, '0, g, w, a, d);

    // Requester 0 asks for a locked burst while requester 1 competes
    set_port(0, 1'b1, 32'h40, 64'h1);
    set_port(1, 1'b1, 32'h41, 64'h2);
    for (int k = 0; k < 10; k++) begin
      cycle(3'b011, 3'b001, g, w, a, d);
`ifdef BRAM_ARB_BURST_EN
      exp_g = ((k % (MAXB + 1)) < MAXB) ? 3'b001 : 3'b010;
`else
      exp_g = (k % 2 == 0) ? 3'b001 : 3'b010;
`endif
      check("burst_gnt", 64'(g), 64'(exp_g));
    end
    req_lock = '0;
    repeat (4) cycle(3'b000, '0, g, w, a, d);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
